stream_patch_ctrl: RTL and testbench
====================================

STREAM_PATCH_CTRL -- requirements
Module: stream_patch_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, pixel bit width.
REQ-002 SHALL have parameters IMAGE_HEIGHT, IMAGE_WIDTH, defaults 4, 4: active image size.
REQ-003 SHALL have parameters FRAME_HEIGHT, FRAME_WIDTH, defaults 6, 6: frame size including sync/blank.
REQ-004 SHALL define V_BITW = ceil(log2(FRAME_HEIGHT)) and H_BITW = ceil(log2(FRAME_WIDTH)).
REQ-005 SHALL have ports, in this order:
- clock  in  1  sole clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start request.
- in_valid  in  1  upstream pixel valid.
- in_pixel  in  BIT_WIDTH  upstream pixel.
- in_ready  out  1  pixel accepted this cycle when in_valid is also high.
- out_pixel  out  BIT_WIDTH  pixel to the patch extractor.
- out_vcnt  out  V_BITW  frame row of out_pixel.
- out_hcnt  out  H_BITW  frame column of out_pixel.
- out_enable  out  1  out_* carry a new frame position (extractor advance).
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last frame position is issued.

Function
REQ-006 SHALL implement states IDLE and RUN.
REQ-007 IDLE -> RUN SHALL occur on start=1, with the counters (vcnt, hcnt) set to (0, 0).
- start in RUN SHALL be ignored.
REQ-008 In RUN, the current position is "active" when vcnt<IMAGE_HEIGHT and hcnt<IMAGE_WIDTH; otherwise it is "blank".
REQ-009 in_ready SHALL be combinational: RUN and active.
REQ-010 advance = RUN and (blank or in_valid).
- At an active position with in_valid=0, the controller SHALL stall: counters hold and no position is issued.
REQ-011 On advance:
- hcnt SHALL increment.
- At hcnt=FRAME_WIDTH-1, hcnt wraps to 0 and vcnt increments.
REQ-012 On advance at (FRAME_HEIGHT-1, FRAME_WIDTH-1):
- counters SHALL wrap to (0, 0).
- frame_done SHALL pulse on the next cycle.
- state SHALL become IDLE (see REQ-019 for continuous mode).
REQ-013 out_pixel, out_vcnt, out_hcnt and out_enable SHALL be registered with latency 1 from advance:
- out_enable = advance.
- out_vcnt/out_hcnt = the pre-increment counter values.
- out_pixel = in_pixel if active, else 0.
REQ-014 When out_enable=0, out_pixel, out_vcnt and out_hcnt SHALL hold their previous values.
REQ-015 busy SHALL equal (state==RUN).
REQ-016 Every frame SHALL issue exactly FRAME_HEIGHT*FRAME_WIDTH positions in raster order, regardless of stalls; blank positions are issued back-to-back so the extractor flushes.

Reset
REQ-017 n_rst=0 SHALL asynchronously force:
- state IDLE.
- counters 0.
- out_pixel, out_vcnt, out_hcnt, out_enable, frame_done = 0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame: no frame_done, and the next frame needs a fresh start.

Configuration
REQ-019 With STREAM_PATCH_CTRL_CONTINUOUS_EN defined:
- the final advance of a frame SHALL stay in RUN at (0, 0), so the next frame begins with no start.
- frame_done SHALL still pulse once per frame.
- busy SHALL stay 1.
Without the macro, REQ-012 applies.

Structure
REQ-020 A shared package stream_ctrl_pkg SHALL hold:
- the state enum (IDLE, RUN).
- the ceil-log2 constant function used for V_BITW and H_BITW.
REQ-021 The raster counter (advance in; vcnt, hcnt, last-position flag out) SHALL be the single sub-module frame_coord_counter.

Verification (IMAGE 4x4, FRAME 6x6, BIT_WIDTH 8)
REQ-022 Reset check: n_rst low mid-frame at (2, 3) -> outputs 0 immediately; busy=0; no frame_done; after n_rst=1 and start, the frame restarts at (0, 0).
REQ-023 Full frame: start, in_valid=1, pixels 0..15 -> 36 out_enable pulses in raster order; active positions carry 0..15, blank positions carry 0; frame_done exactly once, 1 cycle after position (5, 5) is issued.
REQ-024 Stall: in_valid=0 for 3 cycles at (1, 2) -> in_ready=1, out_enable=0, out_* hold for those 3 cycles; then (1, 2) is issued with the pixel presented when in_valid returns.
REQ-025 Blank ignores valid: in_valid=0 throughout rows 4-5 -> positions (4, 0)..(5, 5) still issued, one per cycle, with in_ready=0.
REQ-026 Start in RUN: start pulsed at (3, 1) -> ignored; still 36 positions, one frame_done.
REQ-027 Continuous mode: STREAM_PATCH_CTRL_CONTINUOUS_EN defined, single start -> two back-to-back frames (72 positions); two frame_done pulses; busy constant 1.

Source files
------------

// File: rtl/stream_ctrl_pkg.sv
// Shared types and constant helpers for the stream controllers: FSM state enum and ceil-log2 sizing.
package stream_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Never returns less than 1 so a degenerate 1-entry dimension still gets a real bit.
  function automatic int ceil_log2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/frame_coord_counter.sv
// Raster (row, column) counter over the full frame; steps on advance, wraps at the frame end.
// last flags the final frame position combinationally so the caller can close the frame on that advance.
module frame_coord_counter #(
  parameter int FRAME_HEIGHT = 6,
  parameter int FRAME_WIDTH  = 6,
  parameter int V_BITW       = 3,
  parameter int H_BITW       = 3
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              advance,
  output logic [V_BITW-1:0] vcnt,
  output logic [H_BITW-1:0] hcnt,
  output logic              last
);

  localparam logic [V_BITW-1:0] LAST_V = V_BITW'(FRAME_HEIGHT - 1);
  localparam logic [H_BITW-1:0] LAST_H = H_BITW'(FRAME_WIDTH - 1);

  assign last = (vcnt == LAST_V) && (hcnt == LAST_H);

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (clear) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (advance) begin
      if (hcnt == LAST_H) begin
        hcnt <= '0;
        vcnt <= (vcnt == LAST_V) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_patch_ctrl.sv
// Feeds a patch extractor one frame position per advance (1-cycle registered outputs); stalls only on active positions without in_valid.
// Blank positions flush back-to-back. STREAM_PATCH_CTRL_CONTINUOUS_EN keeps RUN across frames without a new start.
module stream_patch_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int  BIT_WIDTH    = 8,
  parameter int  IMAGE_HEIGHT = 4,
  parameter int  IMAGE_WIDTH  = 4,
  parameter int  FRAME_HEIGHT = 6,
  parameter int  FRAME_WIDTH  = 6,
  localparam int V_BITW       = ceil_log2(FRAME_HEIGHT),
  localparam int H_BITW       = ceil_log2(FRAME_WIDTH)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_pixel,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_pixel,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic                 out_enable,
  output logic                 busy,
  output logic                 frame_done
);

  // One extra bit so an image dimension equal to a power of two still compares correctly.
  localparam logic [V_BITW:0] IMG_ROWS = (V_BITW + 1)'(IMAGE_HEIGHT);
  localparam logic [H_BITW:0] IMG_COLS = (H_BITW + 1)'(IMAGE_WIDTH);

  state_t              state;
  logic [V_BITW-1:0]   vcnt;
  logic [H_BITW-1:0]   hcnt;
  logic                last;
  logic                active;
  logic                advance;

  assign active   = (state == RUN) && ({1'b0, vcnt} < IMG_ROWS) && ({1'b0, hcnt} < IMG_COLS);
  assign in_ready = active;
  assign advance  = (state == RUN) && (!active || in_valid);
  assign busy     = (state == RUN);

  frame_coord_counter #(
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .FRAME_WIDTH  (FRAME_WIDTH),
    .V_BITW       (V_BITW),
    .H_BITW       (H_BITW)
  ) u_coord (
    .clock   (clock),
    .n_rst   (n_rst),
    .clear   ((state == IDLE) && start),
    .advance (advance),
    .vcnt    (vcnt),
    .hcnt    (hcnt),
    .last    (last)
  );

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      out_pixel  <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
      out_enable <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_enable <= advance;
      frame_done <= advance && last;
      if (advance) begin
        out_pixel <= active ? in_pixel : '0;
        out_vcnt  <= vcnt;
        out_hcnt  <= hcnt;
      end
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (advance && last) begin
`ifdef STREAM_PATCH_CTRL_CONTINUOUS_EN
            state <= RUN;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_patch_ctrl.sv
// Bench for stream_patch_ctrl: reset-state table, then frame-level reference model driven by directed and random stimulus.
module tb_stream_patch_ctrl;

  localparam int BW = 8, IH = 4, IW = 4, FH = 6, FW = 6;
`ifdef STREAM_PATCH_CTRL_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_pixel = '0;
  logic          in_ready;
  logic [BW-1:0] out_pixel;
  logic [2:0]    out_vcnt;
  logic [2:0]    out_hcnt;
  logic          out_enable;
  logic          busy;
  logic          frame_done;

  stream_patch_ctrl #(
    .BIT_WIDTH(BW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW), .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW)
  ) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .out_pixel(out_pixel), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .out_enable(out_enable), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position index plus the expected registered outputs.
  bit            m_run;
  int            m_idx;
  bit            m_acc;
  logic          e_en, e_done;
  logic [2:0]    e_v, e_h;
  logic [BW-1:0] e_pix;
  int            dut_en_cnt, dut_done_cnt;
  logic          drv_start, drv_valid;
  logic [BW-1:0] drv_pixel;

  typedef struct {
    logic st; logic vl; logic [7:0] px;
    logic rdy; logic en; logic [2:0] v; logic [2:0] h; logic [7:0] op; logic dn; logic bz;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, out_enable, frame_done, busy, out_vcnt, out_hcnt, out_pixel};
  endfunction

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_acc = 0;
    e_en = 0; e_done = 0; e_v = 0; e_h = 0; e_pix = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step();
    bit act, adv;
    start = drv_start; in_valid = drv_valid; in_pixel = drv_pixel;
    #1;
    act = m_run && (m_idx / FW < IH) && (m_idx % FW < IW);
    adv = m_run && (!act || drv_valid);
    chk("in_ready", {31'd0, in_ready}, {31'd0, act});
    chk("busy_pre", {31'd0, busy}, {31'd0, m_run});
    @(posedge clock);
    #1;
    e_en = adv; e_done = 0; m_acc = adv && act;
    if (adv) begin
      e_v = 3'(m_idx / FW); e_h = 3'(m_idx % FW);
      e_pix = act ? drv_pixel : '0;
      m_idx++;
      if (m_idx == FH * FW) begin
        m_idx = 0; e_done = 1;
        if (!CONT) m_run = 0;
      end
    end else if (!m_run && drv_start) begin
      m_run = 1; m_idx = 0;
    end
    if (out_enable) dut_en_cnt++;
    if (frame_done) dut_done_cnt++;
    chk("outputs", outs(), {15'd0, e_en, e_done, m_run, e_v, e_h, e_pix});
  endtask

  // mode 0: pixels 0..15, always valid; 1: stall at (1,2), idle valid in rows 4-5, start at (3,1); 2: random.
  task automatic run_frame(input int mode);
    int stall;
    bit got;
    logic [BW-1:0] pix_next;
    dut_en_cnt = 0; dut_done_cnt = 0; stall = 0; got = 0;
    pix_next = (mode == 0) ? '0 : 8'($urandom);
    for (int c = 0; c < 400 && !got; c++) begin
      drv_start = !m_run; drv_valid = 1'b1; drv_pixel = pix_next;
      if (mode == 1) begin
        if (m_run && m_idx == 8 && stall < 3) begin
          drv_valid = 1'b0; drv_pixel = 8'($urandom); stall++;
        end
        if (m_idx >= 24) drv_valid = 1'b0;
        if (m_idx == 19) drv_start = 1'b1;
      end else if (mode == 2) begin
        drv_valid = ($urandom_range(0, 3) != 0);
        if (m_run && $urandom_range(0, 7) == 0) drv_start = 1'b1;
      end
      step();
      if (m_acc) pix_next = (mode == 0) ? pix_next + 1'b1 : 8'($urandom);
      got = e_done;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL frame_budget mode=%0d actual=no_frame_done required=frame_done", mode);
    end
    chk("frame_positions", dut_en_cnt, FH * FW);
    chk("frame_done_count", dut_done_cnt, 1);
  endtask

  task automatic reset_dut();
    n_rst = 1'b0; start = 0; in_valid = 0; in_pixel = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    //         st vl px     rdy en v  h  op     dn bz
    tbl[0] = '{1, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1};
    tbl[1] = '{0, 1, 8'hA1, 1,  1, 0, 0, 8'hA1, 0, 1};
    tbl[2] = '{0, 0, 8'h5A, 1,  0, 0, 0, 8'hA1, 0, 1};
    tbl[3] = '{0, 1, 8'hB2, 1,  1, 0, 1, 8'hB2, 0, 1};
    tbl[4] = '{0, 1, 8'hC3, 1,  1, 0, 2, 8'hC3, 0, 1};
    tbl[5] = '{0, 1, 8'hD4, 1,  1, 0, 3, 8'hD4, 0, 1};
    tbl[6] = '{0, 0, 8'hEE, 0,  1, 0, 4, 8'h00, 0, 1};
    tbl[7] = '{0, 1, 8'hFF, 0,  1, 0, 5, 8'h00, 0, 1};
    tbl[8] = '{0, 1, 8'h11, 1,  1, 1, 0, 8'h11, 0, 1};
    tbl[9] = '{1, 0, 8'h22, 1,  0, 1, 0, 8'h11, 0, 1};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd0);
    n_rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; in_valid = tbl[i].vl; in_pixel = tbl[i].px;
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_out", i), outs(),
          {15'd0, tbl[i].en, tbl[i].dn, tbl[i].bz, tbl[i].v, tbl[i].h, tbl[i].op});
    end

    // Mid-frame asynchronous reset at (2,3), then a fresh start from (0,0).
    reset_dut();
    for (int c = 0; c < 60 && !(m_run && m_idx == 15); c++) begin
      drv_start = !m_run; drv_valid = 1'b1; drv_pixel = 8'($urandom);
      step();
    end
    chk("reached_2_3", m_idx, 15);
    n_rst = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drv_start = 1'b0; drv_valid = 1'b1; drv_pixel = 8'h77;
      step();
    end

    run_frame(0);
    run_frame(CONT ? 0 : 1);
    run_frame(1);
    for (int f = 0; f < 3; f++) run_frame(2);
    for (int c = 0; c < 3; c++) begin
      drv_start = 1'b0; drv_valid = 1'b1; drv_pixel = 8'h00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
